bird_game_ctrl: RTL and testbench

Top-level game sequencer for the FPGA Flappy Bird LED-matrix design. It owns the game tick divider and the IDLE/PLAY/LOST state machine. Each tick it moves the bird's row (flap up or gravity down) and issues the scroll strobe to the pipe generator. It also detects ground and pipe collisions, drives the loss indication, and keeps the score.

---
 rtl/bird_game_ctrl.sv | 127 ++++++++++++
 tb/tb_bird_game_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_game_ctrl.sv
// Flappy Bird game sequencer: tick divider, IDLE/PLAY/LOST control, bird row motion,
// ground/pipe collision detection and saturating score.
module bird_game_ctrl #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned ROW_W     = 3,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned TICK_DIV  = 1792,
  parameter int unsigned START_ROW = 3,
  parameter int unsigned FLAP_UP   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_in,
  input  logic [ROWS-1:0]  pipe_mask,
  input  logic             pipe_pass,
  output logic             tick,
  output logic [ROW_W-1:0] bird_row,
  output logic [ROWS-1:0]  bird_onehot,
  output logic [1:0]       state,
  output logic             loss,
  output logic [7:0]       score
);

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_DIV - 1);
  localparam logic [ROW_W-1:0] StartRow = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] FlapUp   = ROW_W'(FLAP_UP);
  localparam logic [ROW_W-1:0] LastRow  = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StLost = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flap_q, flap_d;
  logic             key_prev_q;
  logic             key_rise;
  logic             collide;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      row_q      <= StartRow;
      score_q    <= '0;
      cnt_q      <= '0;
      flap_q     <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      score_q    <= score_d;
      cnt_q      <= cnt_d;
      flap_q     <= flap_d;
      key_prev_q <= key_in;
    end
  end

  always_comb begin
    key_rise = key_in & ~key_prev_q;
    tick     = (state_q == StPlay) && (cnt_q == TickLast);
    collide  = pipe_mask[row_q];

    state_d = state_q;
    row_d   = row_q;
    score_d = score_q;
    flap_d  = flap_q;
    cnt_d   = '0;

    unique case (state_q)
      StIdle: begin
        row_d = StartRow;
        if (key_rise) begin
          state_d = StPlay;
          score_d = '0;
          flap_d  = 1'b0;
        end
      end
      StPlay: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        // A pipe hit freezes row, score and pending flap in the same cycle.
        if (collide) begin
          state_d = StLost;
        end else begin
          if (tick) begin
            if (flap_q || key_rise) begin
              row_d  = (row_q >= FlapUp) ? row_q - FlapUp : '0;
              flap_d = 1'b0;
            end else if (row_q == LastRow) begin
              state_d = StLost;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else if (key_rise) begin
            flap_d = 1'b1;
          end
          if (pipe_pass && (score_q != 8'hFF)) begin
            score_d = score_q + 1'b1;
          end
        end
        if (state_d != StPlay) begin
          cnt_d = '0;
        end
      end
      StLost: begin
        if (key_rise) begin
          state_d = StIdle;
          row_d   = StartRow;
        end
      end
      default: begin
        state_d = StIdle;
        row_d   = StartRow;
      end
    endcase
  end

  assign bird_row    = row_q;
  assign bird_onehot = ROWS'(1) << row_q;
  assign state       = state_q;
  assign loss        = (state_q == StLost);
  assign score       = score_q;

endmodule

// File: tb/tb_bird_game_ctrl.sv
// Scoreboard bench for bird_game_ctrl: stimulus queues expected state/row/score changes and
// tick cycle stamps; a negedge monitor pops and compares whenever the DUT output changes.
module tb_bird_game_ctrl;

  localparam logic [1:0] SIdle = 2'b00;
  localparam logic [1:0] SPlay = 2'b01;
  localparam logic [1:0] SLost = 2'b10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_in = 1'b0;
  logic [7:0] pipe_mask = 8'h00;
  logic       pipe_pass = 1'b0;
  logic       tick;
  logic [2:0] bird_row;
  logic [7:0] bird_onehot;
  logic [1:0] state;
  logic       loss;
  logic [7:0] score;

  bird_game_ctrl #(
    .ROWS     (8),
    .ROW_W    (3),
    .CNT_W    (11),
    .TICK_DIV (4),
    .START_ROW(3),
    .FLAP_UP  (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_in     (key_in),
    .pipe_mask  (pipe_mask),
    .pipe_pass  (pipe_pass),
    .tick       (tick),
    .bird_row   (bird_row),
    .bird_onehot(bird_onehot),
    .state      (state),
    .loss       (loss),
    .score      (score)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] row;
    logic [7:0] sc;
    logic       lo;
  } obs_t;

  obs_t exp_q[$];
  int   tick_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  int   resync_req = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every change of the observed tuple consumes one expected entry.
  always @(negedge clock) begin : monitor
    obs_t       cur;
    obs_t       e;
    obs_t       last;
    int         resync_seen;
    int         t;
    logic [7:0] oh;
    cur.st  = state;
    cur.row = bird_row;
    cur.sc  = score;
    cur.lo  = loss;
    if (mon_en) begin
      if (resync_req != resync_seen || cur != last) begin
        resync_seen = resync_req;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL obs_unexpected got st=%b row=%0d score=%0d loss=%b required none",
                   cur.st, cur.row, cur.sc, cur.lo);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL obs got st=%b row=%0d score=%0d loss=%b required st=%b row=%0d score=%0d loss=%b",
                     cur.st, cur.row, cur.sc, cur.lo, e.st, e.row, e.sc, e.lo);
          end
          checks++;
          oh = 8'd1 << e.row;
          if (bird_onehot !== oh) begin
            failures++;
            $display("FAIL onehot got %b required %b", bird_onehot, oh);
          end
        end
      end
      if (tick === 1'b1) begin
        checks++;
        if (tick_q.size() == 0) begin
          failures++;
          $display("FAIL tick_unexpected at cycle %0d required no tick", cyc);
        end else begin
          t = tick_q.pop_front();
          if (cyc != t) begin
            failures++;
            $display("FAIL tick_cycle got %0d required %0d", cyc, t);
          end
        end
      end
      if (reset) begin
        checks++;
        if (tick !== 1'b0) begin
          failures++;
          $display("FAIL tick_in_reset got %b required 0", tick);
        end
      end
    end
    last = cur;
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || tick_q.size() != 0) begin
        failures++;
        $display("FAIL leftover got obs=%0d ticks=%0d required 0 0", exp_q.size(), tick_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic void exp_obs(input logic [1:0] st, input int row, input int sc);
    obs_t o;
    o.st  = st;
    o.row = 3'(row);
    o.sc  = 8'(sc);
    o.lo  = (st == SLost);
    exp_q.push_back(o);
  endfunction

  // Ticks land 3 cycles after the PLAY entry edge, then every 4 cycles.
  function automatic void exp_ticks(input int base, input int n);
    for (int k = 0; k < n; k++) tick_q.push_back(base + 3 + 4 * k);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    reset = 1'b0;
    exp_obs(SIdle, 3, 0);
    resync_req++;
    mon_en = 1'b1;
    step(2);

    // Start and fall to the ground
    exp_obs(SPlay, 3, 0);
    exp_obs(SPlay, 4, 0);
    exp_obs(SPlay, 5, 0);
    exp_obs(SPlay, 6, 0);
    exp_obs(SPlay, 7, 0);
    exp_obs(SLost, 7, 0);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    exp_ticks(cyc, 5);
    step(26);

    // Back to IDLE, then new game: flaps, ceiling, double press
    exp_obs(SIdle, 3, 0);
    exp_obs(SPlay, 3, 0);
    exp_obs(SPlay, 1, 0);
    exp_obs(SPlay, 0, 0);
    exp_obs(SPlay, 1, 0);
    exp_obs(SPlay, 1, 1);
    exp_obs(SPlay, 1, 2);
    exp_obs(SPlay, 2, 2);
    exp_obs(SPlay, 2, 3);
    exp_obs(SPlay, 3, 3);
    exp_obs(SPlay, 4, 3);
    exp_obs(SLost, 4, 3);
    exp_obs(SIdle, 3, 3);
    exp_obs(SPlay, 3, 0);
    exp_obs(SPlay, 4, 1);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    step(1);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    exp_ticks(cyc, 7);
    step(1);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    step(2);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    step(1);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    step(5);

    // Scoring, then collision on a tick cycle with pipe_pass
    pipe_pass = 1'b1;
    step(1);
    pipe_pass = 1'b0;
    step(1);
    pipe_pass = 1'b1;
    step(1);
    pipe_pass = 1'b0;
    step(1);
    pipe_pass = 1'b1;
    step(1);
    pipe_pass = 1'b0;
    step(10);
    pipe_mask = 8'b0001_0000;
    pipe_pass = 1'b1;
    step(3);
    pipe_mask = 8'h00;
    pipe_pass = 1'b0;

    // LOST -> IDLE keeps score; IDLE -> PLAY clears it; pass on a tick counts
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    step(1);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    exp_ticks(cyc, 1);
    step(3);
    pipe_pass = 1'b1;
    step(1);
    pipe_pass = 1'b0;
    step(1);

    // Score saturation while flapping against the ceiling
    mon_en = 1'b0;
    for (int i = 0; i < 260; i++) begin
      key_in    = i[0];
      pipe_pass = 1'b1;
      step(1);
    end
    exp_obs(SPlay, 0, 255);
    exp_obs(SIdle, 3, 0);
    key_in    = 1'b1;
    pipe_pass = 1'b1;
    reset     = 1'b1;
    resync_req++;
    mon_en    = 1'b1;
    step(3);
    reset     = 1'b0;
    key_in    = 1'b0;
    pipe_pass = 1'b0;
    step(3);

    // Reset mid-game at row 6, score 5
    exp_obs(SPlay, 3, 0);
    exp_obs(SPlay, 3, 1);
    exp_obs(SPlay, 3, 2);
    exp_obs(SPlay, 3, 3);
    exp_obs(SPlay, 4, 3);
    exp_obs(SPlay, 4, 4);
    exp_obs(SPlay, 4, 5);
    exp_obs(SPlay, 5, 5);
    exp_obs(SPlay, 6, 5);
    exp_obs(SIdle, 3, 0);
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    exp_ticks(cyc, 3);
    pipe_pass = 1'b1;
    step(3);
    pipe_pass = 1'b0;
    step(1);
    pipe_pass = 1'b1;
    step(2);
    pipe_pass = 1'b0;
    step(6);
    reset     = 1'b1;
    key_in    = 1'b1;
    pipe_pass = 1'b1;
    pipe_mask = 8'hFF;
    step(3);
    reset     = 1'b0;
    key_in    = 1'b0;
    pipe_pass = 1'b0;
    pipe_mask = 8'h00;
    step(3);
    done = 1'b1;
    step(2);
  end

endmodule
